// File: rtl/pcie_tx_ab_order_gate.sv
`default_nettype none
// ============================================================================
// pcie_tx_ab_order_gate : holds TX B packets until all earlier TX A writes
// are committed on RX B. Optional stats: define ORDER_GATE_STATS_EN.
// Revision: 1.0
// ============================================================================

package pcie_ss_axis_pkg;
  localparam int TDATA_WIDTH = 512;
  localparam int TUSER_WIDTH = 10;
endpackage

module pcie_tx_ab_order_gate #(
  parameter int TDATA_WIDTH     = pcie_ss_axis_pkg::TDATA_WIDTH,
  parameter int TUSER_WIDTH     = pcie_ss_axis_pkg::TUSER_WIDTH,
  parameter int CNT_W           = 10,
  parameter int MAX_OUTSTANDING = 256
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   s_tx_a_tvalid,
  output logic                   s_tx_a_tready,
  input  logic                   s_tx_a_tlast,
  input  logic [TDATA_WIDTH-1:0] s_tx_a_tdata,
  input  logic [TUSER_WIDTH-1:0] s_tx_a_tuser,
  output logic                   m_tx_a_tvalid,
  input  logic                   m_tx_a_tready,
  output logic                   m_tx_a_tlast,
  output logic [TDATA_WIDTH-1:0] m_tx_a_tdata,
  output logic [TUSER_WIDTH-1:0] m_tx_a_tuser,

  input  logic                   s_tx_b_tvalid,
  output logic                   s_tx_b_tready,
  input  logic                   s_tx_b_tlast,
  input  logic [TDATA_WIDTH-1:0] s_tx_b_tdata,
  input  logic [TUSER_WIDTH-1:0] s_tx_b_tuser,
  output logic                   m_tx_b_tvalid,
  input  logic                   m_tx_b_tready,
  output logic                   m_tx_b_tlast,
  output logic [TDATA_WIDTH-1:0] m_tx_b_tdata,
  output logic [TUSER_WIDTH-1:0] m_tx_b_tuser,

  input  logic                   rx_b_tvalid,
  input  logic                   rx_b_tready,
  input  logic                   rx_b_tlast,

`ifdef ORDER_GATE_STATS_EN
  output logic [31:0]            b_stall_cycles,
  output logic [CNT_W-1:0]       max_outstanding,
`endif
  output logic [CNT_W-1:0]       outstanding,
  output logic                   commit_err
);

  localparam logic [CNT_W-1:0] C_MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_OPEN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] commit_cnt_q, commit_cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             a_sop_q, a_sop_d;
  logic             a_wr_q, a_wr_d;
  logic             commit_err_q, commit_err_d;

  logic             a_full;
  logic             a_beat;
  logic             a_sop_wr;
  logic             a_is_wr;
  logic             issue_inc;
  logic             rx_commit;
  logic             commit_inc;
  logic [CNT_W-1:0] b_gap;
  logic             b_open_ok;

  assign outstanding = issue_cnt_q - commit_cnt_q;
  assign a_full      = (outstanding == C_MAX_OUT);
  assign commit_err  = commit_err_q;

  // Both handshake outputs are forced low while reset is held.
  assign s_tx_a_tready = m_tx_a_tready & ~a_full & ~rst;
  assign m_tx_a_tvalid = s_tx_a_tvalid & ~a_full & ~rst;
  assign m_tx_a_tlast  = s_tx_a_tlast;
  assign m_tx_a_tdata  = s_tx_a_tdata;
  assign m_tx_a_tuser  = s_tx_a_tuser;

  assign m_tx_b_tlast  = s_tx_b_tlast;
  assign m_tx_b_tdata  = s_tx_b_tdata;
  assign m_tx_b_tuser  = s_tx_b_tuser;

  assign a_beat   = s_tx_a_tvalid & s_tx_a_tready;
  assign a_sop_wr = (s_tx_a_tdata[31:24] == 8'h40) || (s_tx_a_tdata[31:24] == 8'h60);
  // Single-beat packets need the SOP decode directly, not the latched flag.
  assign a_is_wr   = a_sop_q ? a_sop_wr : a_wr_q;
  assign issue_inc = a_beat & s_tx_a_tlast & a_is_wr;

  assign rx_commit  = rx_b_tvalid & rx_b_tready & rx_b_tlast;
  assign commit_inc = rx_commit & (outstanding != '0);

  assign a_sop_d      = a_beat ? s_tx_a_tlast : a_sop_q;
  assign a_wr_d       = a_beat ? a_is_wr : a_wr_q;
  assign issue_cnt_d  = issue_cnt_q + CNT_W'(issue_inc);
  assign commit_cnt_d = commit_cnt_q + CNT_W'(commit_inc);
  assign commit_err_d = commit_err_q | (rx_commit & (outstanding == '0));

  // Commit count has reached or wrapped past the target.
  assign b_gap     = target_q - commit_cnt_q;
  assign b_open_ok = (b_gap == '0) || b_gap[CNT_W-1];

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    m_tx_b_tvalid = 1'b0;
    s_tx_b_tready = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_tx_b_tvalid) begin
          target_d = issue_cnt_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (b_open_ok) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        m_tx_b_tvalid = s_tx_b_tvalid & ~rst;
        s_tx_b_tready = m_tx_b_tready & ~rst;
        if (s_tx_b_tvalid & m_tx_b_tready & s_tx_b_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      issue_cnt_q  <= '0;
      commit_cnt_q <= '0;
      target_q     <= '0;
      a_sop_q      <= 1'b1;
      a_wr_q       <= 1'b0;
      commit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_cnt_q  <= issue_cnt_d;
      commit_cnt_q <= commit_cnt_d;
      target_q     <= target_d;
      a_sop_q      <= a_sop_d;
      a_wr_q       <= a_wr_d;
      commit_err_q <= commit_err_d;
    end
  end

`ifdef ORDER_GATE_STATS_EN
  logic [31:0]      b_stall_q, b_stall_d;
  logic [CNT_W-1:0] max_out_q, max_out_d;

  assign b_stall_d = ((state_q == ST_WAIT) && (b_stall_q != '1)) ? b_stall_q + 32'd1 : b_stall_q;
  assign max_out_d = (outstanding > max_out_q) ? outstanding : max_out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      b_stall_q <= '0;
      max_out_q <= '0;
    end else begin
      b_stall_q <= b_stall_d;
      max_out_q <= max_out_d;
    end
  end

  assign b_stall_cycles  = b_stall_q;
  assign max_outstanding = max_out_q;
`endif

endmodule

`default_nettype wire
